coin_input_conditioner: RTL
===========================

Name: coin_input_conditioner

Overview:
Upstream front end for the vending-machine FSM. Takes raw, asynchronous and bouncy inputs from the coin sensors and the cancel button. Synchronises and debounces each input, detects presses, and issues clean single-cycle fifty/dollar/cancel pulses, at most one per cycle. Events are held pending while the downstream FSM signals busy (dispense or return active).

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required before a debounced level changes
CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  single system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
coin50_raw  input  1  raw 50-cent sensor, asynchronous, bouncy
coin100_raw  input  1  raw dollar sensor, asynchronous, bouncy
cancel_raw  input  1  raw cancel button, asynchronous, bouncy
busy  input  1  downstream FSM in dispense/return; high = do not issue pulses
fifty  output  1  one-cycle pulse: 50-cent coin accepted
dollar  output  1  one-cycle pulse: dollar coin accepted
cancel  output  1  one-cycle pulse: cancel requested
pending  output  3  {cancel,dollar,fifty} events latched but not yet issued

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. When rst=0, all flops clear immediately: sync stages, debounced levels, counters, pending, and all outputs go to 0. On release, the first sampling happens on the next rising clk.
- Synchroniser: each raw input passes through 2 flops. Synchronised level s_x lags the raw input by 2 cycles.
- Debounce, per channel:
  - Counter compares s_x with debounced level d_x.
  - If s_x != d_x, counter increments; otherwise counter clears to 0.
  - When counter reaches DEBOUNCE_CYCLES-1 with s_x still != d_x, d_x <= s_x and counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count; d_x does not change.
- Edge detect: a 0->1 transition of d_x sets pending[x] in the same cycle d_x updates. The 1->0 transition does nothing.
- Pending latch:
  - pending[x] is one bit per channel, so events do not queue.
  - If an edge arrives while pending[x] is already 1, it is dropped. This covers a second coin of the same type arriving while blocked.
- Issue, registered outputs:
  - When busy=0 and pending!=0, exactly one output pulses high for 1 cycle in the next cycle, and its pending bit clears.
  - Priority is cancel > dollar > fifty.
  - When busy=1, no output pulses and pending is held.
  - Minimum latency from raw edge to output pulse is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, with busy=0.
- Simultaneous events:
  - A pending set and an issue on the same channel in the same cycle: the issue clears the old bit and the new edge sets it again, so the bit ends at 1 (second event retained).
  - Multiple channels pending: issued one per cycle in priority order, which gives back-to-back pulses when busy stays 0.
- Outputs are mutually exclusive every cycle: fifty+dollar+cancel <= 1.
- Reset mid-operation discards all pending events and partial debounce counts. No pulse is emitted after reset release unless a new stable press occurs.
- busy is assumed synchronous to clk and is not synchronised here.

Test Plan:
- Reset: hold rst=0 with coin50_raw=1 for 10 cycles -> all outputs and pending=0. After release, fifty pulses once, exactly 2+16+1=19 cycles after the release edge.
- Clean press: coin100_raw 0->1 held 40 cycles, busy=0 -> dollar high for exactly 1 cycle, 19 cycles after the edge. No further pulse when the input is held or released.
- Bounce: coin50_raw toggles every 3 cycles for 30 cycles, then holds 1 -> single fifty pulse, 19 cycles after the final rising edge. A 10-cycle glitch alone produces no pulse.
- Priority: cancel_raw and coin50_raw rise in the same cycle with busy=0 -> cancel pulses at cycle N, fifty at N+1, and pending ends at 0.
- Busy hold: busy=1 while a dollar press debounces, held 50 cycles -> no pulse and pending=3'b010. One cycle after busy falls, dollar pulses.
- Drop and async reset: two dollar presses while busy=1 -> only one dollar pulse after busy falls. Asserting rst=0 mid-count, between clock edges, clears pending immediately and no pulse follows.

Source files
------------

// File: rtl/coin_input_conditioner.sv
// Front end for the vending-machine FSM: synchronises and debounces the coin and cancel inputs,
// latches rising edges as pending events and issues them one per cycle while the FSM is not busy.
module coin_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin50_raw,
   input  logic       coin100_raw,
   input  logic       cancel_raw,
   input  logic       busy,
   output logic       fifty,
   output logic       dollar,
   output logic       cancel,
   output logic [2:0] pending
);

   localparam int NumCh = 3;
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channel bit order everywhere: {cancel, dollar, fifty}.
   logic [NumCh-1:0] raw;
   logic [NumCh-1:0] sync1_q, sync2_q;
   logic [NumCh-1:0] deb_q, deb_d;
   logic [NumCh-1:0] rise;
   logic [CNT_W-1:0] cnt_q [NumCh];
   logic [CNT_W-1:0] cnt_d [NumCh];
   logic [NumCh-1:0] pending_q, pending_d;
   logic [NumCh-1:0] issue_d;
   logic [NumCh-1:0] out_q;

   assign raw = {cancel_raw, coin100_raw, coin50_raw};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // The debounced level follows only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      deb_d = deb_q;
      rise  = '0;
      for (int i = 0; i < NumCh; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               deb_d[i] = sync2_q[i];
               rise[i]  = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_q <= '0;
         for (int i = 0; i < NumCh; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < NumCh; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Fixed priority cancel > dollar > fifty; a new edge on the channel being issued re-arms it.
   always_comb begin
      issue_d = '0;
      if (!busy) begin
         if (pending_q[2]) begin
            issue_d = 3'b100;
         end else if (pending_q[1]) begin
            issue_d = 3'b010;
         end else if (pending_q[0]) begin
            issue_d = 3'b001;
         end
      end
      pending_d = (pending_q & ~issue_d) | rise;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= '0;
         out_q     <= '0;
      end else begin
         pending_q <= pending_d;
         out_q     <= issue_d;
      end
   end

   assign fifty   = out_q[0];
   assign dollar  = out_q[1];
   assign cancel  = out_q[2];
   assign pending = pending_q;

endmodule
